freq_dwell_sequencer: RTL and testbench

FREQ_DWELL_SEQUENCER -- requirements
Module: freq_dwell_sequencer

---
 rtl/freq_dwell_sequencer.sv | 144 ++++++++++++++
 tb/tb_freq_dwell_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_dwell_sequencer.sv
// Tone sequencer: pops 4-bit frequency codes from a ring buffer and holds each
// one for a programmable dwell, with an arbitrated host readback over the ring's random port.
module freq_dwell_sequencer #(
    parameter int DWELL_W  = 16,
    parameter int RAND_TMO = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [DWELL_W-1:0] dwell_len,
    input  logic [3:0]         ring_dout,
    input  logic               ring_ready,
    input  logic [6:0]         ring_index,
    input  logic [7:0]         ring_count,
    output logic               ring_rd_en,
    output logic [6:0]         rand_rd_addr,
    output logic               rand_rd_en,
    input  logic               rand_rd_valid,
    output logic [3:0]         freq_code,
    output logic [6:0]         freq_index,
    output logic               freq_valid,
    output logic               freq_strobe,
    input  logic [6:0]         host_addr,
    input  logic               host_req,
    output logic [3:0]         host_data,
    output logic               host_ack,
    output logic               host_err,
    output logic               err_empty
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] LATCH = 2'd2;
    localparam logic [1:0] DWELL = 2'd3;

    localparam logic [1:0] H_IDLE  = 2'd0;
    localparam logic [1:0] H_PEND  = 2'd1;
    localparam logic [1:0] H_ISSUE = 2'd2;
    localparam logic [1:0] H_WAIT  = 2'd3;

    localparam int TMO_W = $clog2(RAND_TMO + 1);

    logic [1:0]         state, state_nxt;
    logic [1:0]         hstate;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [DWELL_W-1:0] dwell_load;
    logic [6:0]         haddr;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               ring_has;
    logic               host_busy;
    logic               host_go;

    assign ring_has   = (ring_count != '0);
    assign host_busy  = (hstate == H_ISSUE) || (hstate == H_WAIT);
    assign dwell_load = (dwell_len < DWELL_W'(2)) ? DWELL_W'(2) : dwell_len;
    // Random reads may only start where they cannot overlap a LATCH on the shared ring_dout.
    assign host_go    = (state == IDLE) || ((state == DWELL) && (dwell_cnt >= DWELL_W'(3)));

    assign ring_rd_en   = (state == LATCH);
    assign rand_rd_en   = (hstate == H_ISSUE);
    assign rand_rd_addr = rand_rd_en ? haddr : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (enable && ring_has) state_nxt = WAIT;
            WAIT: begin
                if (!enable || !ring_has)
                    state_nxt = IDLE;
                else if (ring_ready && !rand_rd_valid && !host_busy)
                    state_nxt = LATCH;
            end
            LATCH: state_nxt = DWELL;
            DWELL: if (dwell_cnt <= DWELL_W'(1)) state_nxt = (enable && ring_has) ? WAIT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dwell_cnt   <= '0;
            freq_code   <= '0;
            freq_index  <= '0;
            freq_valid  <= 1'b0;
            freq_strobe <= 1'b0;
            err_empty   <= 1'b0;
        end else begin
            state       <= state_nxt;
            freq_strobe <= (state == LATCH);
            err_empty   <= (state == IDLE) && enable && !ring_has;
            if (state == LATCH) begin
                freq_code  <= ring_dout;
                freq_index <= ring_index;
                dwell_cnt  <= dwell_load;
                freq_valid <= 1'b1;
            end else if (state == DWELL) begin
                dwell_cnt <= dwell_cnt - DWELL_W'(1);
            end
            if (state_nxt == IDLE) freq_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hstate    <= H_IDLE;
            haddr     <= '0;
            tmo_cnt   <= '0;
            host_data <= '0;
            host_ack  <= 1'b0;
            host_err  <= 1'b0;
        end else begin
            host_ack <= 1'b0;
            host_err <= 1'b0;
            case (hstate)
                H_IDLE: if (host_req) begin
                    haddr  <= host_addr;
                    hstate <= H_PEND;
                end
                H_PEND: if (host_go) hstate <= H_ISSUE;
                H_ISSUE: begin
                    tmo_cnt <= '0;
                    hstate  <= H_WAIT;
                end
                H_WAIT: begin
                    if (rand_rd_valid) begin
                        host_data <= ring_dout;
                        host_ack  <= 1'b1;
                        hstate    <= H_IDLE;
                    end else if (tmo_cnt == TMO_W'(RAND_TMO - 1)) begin
                        host_data <= '0;
                        host_ack  <= 1'b1;
                        host_err  <= 1'b1;
                        hstate    <= H_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                default: hstate <= H_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_freq_dwell_sequencer.sv
// Bench for freq_dwell_sequencer: IDLE/empty vector table, directed dwell/host
// sequences, then random traffic against a transaction-level ring/tone model.
module tb_freq_dwell_sequencer;

    localparam int DW  = 16;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [DW-1:0] dwell_len = '0;
    logic [3:0]    ring_dout;
    logic          ring_ready;
    logic [6:0]    ring_index;
    logic [7:0]    ring_count;
    logic          ring_rd_en;
    logic [6:0]    rand_rd_addr;
    logic          rand_rd_en;
    logic          rand_rd_valid;
    logic [3:0]    freq_code;
    logic [6:0]    freq_index;
    logic          freq_valid;
    logic          freq_strobe;
    logic [6:0]    host_addr = '0;
    logic          host_req = 1'b0;
    logic [3:0]    host_data;
    logic          host_ack;
    logic          host_err;
    logic          err_empty;

    always #5 clk = ~clk;

    // ring buffer model: circular list of ring_n entries, random port reads any of mem[]
    logic [3:0] mem [128];
    int         ring_n = 3;
    int         rd_ptr = 0;
    logic [7:0] ring_cnt = 8'd0;
    logic       ring_rdy = 1'b0;
    logic       rv = 1'b0;
    logic [6:0] rv_addr = '0;
    int         rv_cnt = 0;

    assign ring_dout     = rv ? mem[rv_addr] : mem[rd_ptr];
    assign ring_index    = 7'(rd_ptr);
    assign ring_count    = ring_cnt;
    assign ring_ready    = ring_rdy;
    assign rand_rd_valid = rv;

    freq_dwell_sequencer #(.DWELL_W(DW), .RAND_TMO(TMO)) dut (
        .clk(clk), .rst(rst), .enable(enable), .dwell_len(dwell_len),
        .ring_dout(ring_dout), .ring_ready(ring_ready), .ring_index(ring_index),
        .ring_count(ring_count), .ring_rd_en(ring_rd_en),
        .rand_rd_addr(rand_rd_addr), .rand_rd_en(rand_rd_en), .rand_rd_valid(rand_rd_valid),
        .freq_code(freq_code), .freq_index(freq_index), .freq_valid(freq_valid),
        .freq_strobe(freq_strobe), .host_addr(host_addr), .host_req(host_req),
        .host_data(host_data), .host_ack(host_ack), .host_err(host_err), .err_empty(err_empty)
    );

    int checks = 0, failures = 0, cyc = 0;

    // tone/host scoreboard state
    int         exp_ptr = 0, pops = 0, strobes = 0, prev_cyc = -1, prev_dl = 0, lat_dl = 0;
    logic [3:0] last_code = '0;
    logic [6:0] last_idx = '0;
    bit         disturbed = 1'b0;
    bit         h_busy = 1'b0, h_issued = 1'b0;
    int         h_addr = 0, h_lat = 0, issue_cyc = 0, ack_cnt = 0, ack_cyc = 0;
    int         s_cyc[$];
    logic [3:0] s_code[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic chk_true(input string name, input bit cond);
        checks++;
        if (!cond) begin
            failures++;
            $display("FAIL %s condition false cycle=%0d", name, cyc);
        end
    endtask

    task automatic tick();
        bit pop, iss, wasrst;
        logic [6:0] ia;
        int dl;
        pop = ring_rd_en; iss = rand_rd_en; ia = rand_rd_addr; wasrst = rst; dl = int'(dwell_len);
        @(posedge clk); #1;
        cyc++;
        if (pop) rd_ptr = (rd_ptr + 1) % ring_n;
        rv = 1'b0;
        if (rv_cnt > 0) begin
            rv_cnt--;
            if (rv_cnt == 0) rv = 1'b1;
        end
        if (wasrst) return;
        if (iss) begin
            chk_true("issue_expected", h_busy && !h_issued);
            chk("rand_rd_addr", ia, h_addr);
            h_issued = 1'b1; issue_cyc = cyc - 1; rv_addr = ia;
            if (h_lat == 1) rv = 1'b1;
            else if (h_lat > 1) rv_cnt = h_lat - 1;
        end
        if (pop) begin
            pops++; lat_dl = dl;
            chk_true("no_latch_during_host_read", !(h_busy && h_issued));
        end
        if (host_ack) begin
            chk_true("stray_host_ack", h_busy && h_issued);
            if (h_busy && h_issued) begin
                if (h_lat == 0) begin
                    chk("host_ack_tmo_latency", cyc - issue_cyc, TMO + 1);
                    chk("host_err_tmo", host_err, 1);
                    chk("host_data_tmo", host_data, 0);
                end else begin
                    chk("host_ack_latency", cyc - issue_cyc, h_lat + 1);
                    chk("host_err", host_err, 0);
                    chk("host_data", host_data, mem[h_addr]);
                end
            end
            h_busy = 1'b0; h_issued = 1'b0; ack_cnt++; ack_cyc = cyc;
        end else if (h_busy && h_issued && (cyc - issue_cyc > TMO + 2)) begin
            checks++; failures++;
            $display("FAIL host_ack_overdue actual=none expected=ack cycle=%0d", cyc);
            h_busy = 1'b0; h_issued = 1'b0;
        end
        if (freq_strobe) begin
            strobes++;
            chk("strobe_pop_count", pops, strobes);
            chk("freq_code", freq_code, mem[exp_ptr]);
            chk("freq_index", freq_index, exp_ptr);
            chk("freq_valid_at_strobe", freq_valid, 1);
            if (prev_cyc >= 0) begin
                int need;
                need = ((prev_dl < 2) ? 2 : prev_dl) + 2;
                chk_true("tone_period_min", cyc - prev_cyc >= need);
                if (!disturbed) chk("tone_period", cyc - prev_cyc, need);
            end
            prev_cyc = cyc; prev_dl = lat_dl; exp_ptr = (exp_ptr + 1) % ring_n;
            last_code = mem[(exp_ptr + ring_n - 1) % ring_n]; last_idx = 7'((exp_ptr + ring_n - 1) % ring_n);
            s_cyc.push_back(cyc); s_code.push_back(freq_code);
            disturbed = h_busy || !enable;
        end else begin
            chk("freq_code_hold", {freq_index, freq_code}, {last_idx, last_code});
            disturbed = disturbed || h_busy || !enable;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; host_req = 1'b0;
        tick();
        chk("reset_outputs", {freq_code, freq_index, freq_valid, freq_strobe, ring_rd_en, rand_rd_en,
                              rand_rd_addr, host_data, host_ack, host_err, err_empty}, 0);
        rst = 1'b0;
        rd_ptr = 0; exp_ptr = 0; pops = 0; strobes = 0; prev_cyc = -1; disturbed = 1'b0;
        h_busy = 1'b0; h_issued = 1'b0; rv = 1'b0; rv_cnt = 0; ack_cnt = 0;
        last_code = '0; last_idx = '0;
        s_cyc.delete(); s_code.delete();
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int k;
        k = 0;
        while (strobes < n && k < budget) begin tick(); k++; end
        chk_true("strobe_wait_budget", strobes >= n);
    endtask

    task automatic wait_ack(input int n, input int budget);
        int k;
        k = 0;
        while (ack_cnt < n && k < budget) begin tick(); k++; end
        chk_true("ack_wait_budget", ack_cnt >= n);
    endtask

    task automatic host_read(input int addr, input int lat);
        host_req = 1'b1; host_addr = 7'(addr);
        h_busy = 1'b1; h_issued = 1'b0; h_addr = addr; h_lat = lat;
        tick();
        host_req = 1'b0;
    endtask

    typedef struct {
        bit         rst;
        bit         en;
        logic [7:0] cnt;
        bit         e_err;
        bit         e_valid;
        bit         e_rd;
    } vec_t;

    vec_t vt[9];

    initial begin
        int sc;
        vt[0] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b0, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0};
        vt[2] = '{1'b0, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0};
        vt[3] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
        vt[4] = '{1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0};
        vt[5] = '{1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0};
        vt[6] = '{1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0};
        vt[7] = '{1'b0, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0};
        vt[8] = '{1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 128; i++) mem[i] = 4'($urandom);
        mem[0] = 4'h5; mem[1] = 4'hA; mem[2] = 4'h3;

        // IDLE / empty-ring behaviour with the ring never ready
        ring_n = 3; ring_rdy = 1'b0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            rst = vt[i].rst; enable = vt[i].en; ring_cnt = vt[i].cnt;
            tick();
            chk($sformatf("vec%0d_err_empty", i), err_empty, vt[i].e_err);
            chk($sformatf("vec%0d_freq_valid", i), freq_valid, vt[i].e_valid);
            chk($sformatf("vec%0d_ring_rd_en", i), ring_rd_en, vt[i].e_rd);
        end
        rst = 1'b0;

        // ring {5,A,3}, dwell 4: period 1 + 4 + 1 WAIT
        ring_cnt = 8'd3; ring_rdy = 1'b1; dwell_len = 16'd4; enable = 1'b0;
        do_reset();
        enable = 1'b1;
        wait_strobes(4, 100);
        if (s_code.size() >= 4) begin
            chk("seqA_code0", s_code[0], 4'h5);
            chk("seqA_code1", s_code[1], 4'hA);
            chk("seqA_code2", s_code[2], 4'h3);
            chk("seqA_code3", s_code[3], 4'h5);
            for (int i = 1; i < 4; i++) chk("seqA_period", s_cyc[i] - s_cyc[i-1], 6);
        end
        chk("seqA_pops", pops, 4);

        // dwell_len 0, 1 and 2 all hold for two cycles
        for (int d = 0; d < 3; d++) begin
            enable = 1'b0; dwell_len = DW'(d);
            do_reset();
            enable = 1'b1;
            wait_strobes(3, 60);
            if (s_cyc.size() >= 3) begin
                chk($sformatf("seqB_dl%0d_period1", d), s_cyc[1] - s_cyc[0], 4);
                chk($sformatf("seqB_dl%0d_period2", d), s_cyc[2] - s_cyc[1], 4);
            end
        end

        // host read of entry 2 during a long dwell, valid 3 cycles after issue
        enable = 1'b0; dwell_len = 16'd10;
        do_reset();
        enable = 1'b1;
        wait_strobes(1, 20);
        tick();
        host_read(2, 3);
        wait_ack(1, 40);
        chk("seqC_host_data", host_data, 4'h3);
        chk("seqC_host_err", host_err, 0);
        chk("seqC_freq_code_held", freq_code, 4'h5);
        tick();
        chk("seqC_ack_one_cycle", host_ack, 0);

        // host read that never gets valid: timeout error
        enable = 1'b0;
        do_reset();
        enable = 1'b1;
        wait_strobes(1, 20);
        tick();
        host_read(1, 0);
        wait_ack(1, 60);
        chk("seqD_host_err", host_err, 1);
        chk("seqD_host_data", host_data, 0);
        chk("seqD_tmo_latency", ack_cyc - issue_cyc, TMO + 1);

        // enable dropped mid-dwell, then reset during a host read
        enable = 1'b0; dwell_len = 16'd8;
        do_reset();
        enable = 1'b1;
        wait_strobes(1, 20);
        tick(); tick();
        enable = 1'b0;
        repeat (5) tick();
        chk("seqE_valid_last_dwell", freq_valid, 1);
        tick();
        chk("seqE_valid_cleared", freq_valid, 0);
        repeat (3) tick();
        chk("seqE_no_more_strobes", strobes, 1);
        host_read(5, 0);
        sc = 0;
        while (!h_issued && sc < 10) begin tick(); sc++; end
        chk_true("seqE_host_issued", h_issued);
        repeat (3) tick();
        do_reset();
        tick();
        chk("seqE_no_ack_after_rst", host_ack, 0);
        chk("seqE_no_strobe_after_rst", freq_strobe, 0);
        repeat (12) tick();
        chk("seqE_ack_count", ack_cnt, 0);

        // ring drains during dwell: finish the tone, then IDLE with err_empty
        enable = 1'b0; dwell_len = 16'd6; ring_cnt = 8'd3; ring_rdy = 1'b1;
        do_reset();
        enable = 1'b1;
        wait_strobes(1, 20);
        tick();
        ring_cnt = 8'd0; ring_rdy = 1'b0;
        repeat (4) tick();
        chk("seqF_valid_during_dwell", freq_valid, 1);
        chk("seqF_no_err_yet", err_empty, 0);
        repeat (3) tick();
        chk("seqF_err_empty", err_empty, 1);
        chk("seqF_valid_cleared", freq_valid, 0);
        chk("seqF_strobes", strobes, 1);
        chk("seqF_pops", pops, 1);

        // random traffic
        enable = 1'b0;
        ring_n = 4 + int'($urandom % 13);
        for (int i = 0; i < 128; i++) mem[i] = 4'($urandom);
        ring_cnt = 8'(ring_n); ring_rdy = 1'b1; dwell_len = 16'd3;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            tick();
            chk("rand_err_empty", err_empty, 0);
            host_req = 1'b0;
            if (!h_busy && ($urandom % 10 == 0)) begin
                host_req = 1'b1; host_addr = 7'($urandom);
                h_busy = 1'b1; h_issued = 1'b0; h_addr = int'(host_addr);
                h_lat = ($urandom % 6 == 0) ? 0 : 1 + int'($urandom % 4);
            end else if (h_busy && ($urandom % 15 == 0)) begin
                host_req = 1'b1; host_addr = 7'($urandom);
            end
            if ($urandom % 4 == 0) dwell_len = DW'($urandom % 13);
            enable = ($urandom % 30 != 0);
        end
        chk_true("rand_strobes_seen", strobes > 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
